// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit_pkg
// Brief   : Shared state encoding and constants for the instruction fetch unit.
// Revision: 1.0
// ============================================================================
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] c_nop    = 32'h0000_0000;
    localparam logic [31:0] c_pc_inc = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Single-outstanding instruction fetch with skid buffer and redirect.
// Revision: 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  buf_q, buf_d;

    logic         w_req;
    logic         w_valid;
    logic [31:0]  w_instr;
    logic [31:0]  w_redir_tgt;

    assign w_redir_tgt = align_word(redirect_pc_i);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        buf_d   = buf_q;
        w_req   = 1'b0;
        w_valid = 1'b0;
        w_instr = c_nop;

        case (state_q)
            ST_FETCH: begin
                w_req = 1'b1;
                if (redirect_i) begin
                    // A response landing with the redirect is stale; drop it.
                    if (imem_ready_i) begin
                        pc_d = w_redir_tgt;
                    end else begin
                        tgt_d   = w_redir_tgt;
                        state_d = ST_KILL;
                    end
                end else if (imem_ready_i) begin
                    w_valid = 1'b1;
                    w_instr = imem_rdata_i;
                    if (stall_i) begin
                        buf_d   = imem_rdata_i;
                        state_d = ST_HOLD;
                    end else begin
                        pc_d = pc_q + c_pc_inc;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d    = w_redir_tgt;
                    state_d = ST_FETCH;
                end else begin
                    w_valid = 1'b1;
                    w_instr = buf_q;
                    if (!stall_i) begin
                        pc_d    = pc_q + c_pc_inc;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_KILL: begin
                // The orphaned request must finish at its original address.
                w_req = 1'b1;
                if (redirect_i) begin
                    tgt_d = w_redir_tgt;
                end
                if (imem_ready_i) begin
                    pc_d    = redirect_i ? w_redir_tgt : tgt_q;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            buf_q   <= buf_d;
        end
    end

    // Reset gates the handshake outputs immediately, without waiting for a clock edge.
    assign imem_req_o  = w_req & ~rst_i;
    assign valid_o     = w_valid & ~rst_i;
    assign instr_o     = valid_o ? w_instr : c_nop;
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;

endmodule
`default_nettype wire
